mem_port_arbiter: RTL and testbench

Round-robin arbiter that shares one memory request/response port among `NUM_REQ` requesters, such as the I-cache, the D-cache and the host-DMA path. The downstream port uses the same protocol as the simulation D-cache memory model: `req_type`, `req_address`, `req_data`, `req_length`, valid/ready request, and address/data valid/ready response. Exactly one transaction is outstanding at a time. The arbiter routes the response back to the requester that issued it. It sits between the cache/DMA clients and the single memory model or DRAM bridge.

---
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side bus bundle of mem_port_arbiter.
// slave is the arbiter's view; master is the view of the clients and memory model around it.
interface mem_port_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32
);
    // Requester side, flattened: requester i occupies [i*XLEN +: XLEN] and [i*2 +: 2]
    logic [NUM_REQ-1:0]      req_type;
    logic [NUM_REQ*XLEN-1:0] req_address;
    logic [NUM_REQ*XLEN-1:0] req_data;
    logic [NUM_REQ*2-1:0]    req_length;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [XLEN-1:0]         resp_address;
    logic [XLEN-1:0]         resp_data;
    logic [NUM_REQ-1:0]      resp_valid;
    logic [NUM_REQ-1:0]      resp_ready;

    // Shared memory port
    logic                    mem_req_type;
    logic [XLEN-1:0]         mem_req_address;
    logic [XLEN-1:0]         mem_req_data;
    logic [1:0]              mem_req_length;
    logic                    mem_req_valid;
    logic                    mem_req_ready;
    logic [XLEN-1:0]         mem_resp_address;
    logic [XLEN-1:0]         mem_resp_data;
    logic                    mem_resp_valid;
    logic                    mem_resp_ready;

    modport slave (
        input  req_type, req_address, req_data, req_length, req_valid, resp_ready,
        input  mem_req_ready, mem_resp_address, mem_resp_data, mem_resp_valid,
        output req_ready, resp_address, resp_data, resp_valid,
        output mem_req_type, mem_req_address, mem_req_data, mem_req_length, mem_req_valid,
        output mem_resp_ready
    );

    modport master (
        output req_type, req_address, req_data, req_length, req_valid, resp_ready,
        output mem_req_ready, mem_resp_address, mem_resp_data, mem_resp_valid,
        input  req_ready, resp_address, resp_data, resp_valid,
        input  mem_req_type, mem_req_address, mem_req_data, mem_req_length, mem_req_valid,
        input  mem_resp_ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ requesters, one transaction in flight.
// Define MEM_ARB_TIMEOUT_EN to build the response watchdog (adds parameter TIMEOUT_CYCLES, >= 1).
module mem_port_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_port_arbiter_if.slave bus,
    output logic              busy,
    output logic              timeout_err
);
    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic             type_q, type_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]  data_q, data_d;
    logic [1:0]       len_q, len_d;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand;
    logic             sel_type;
    logic [XLEN-1:0]  sel_addr;
    logic [XLEN-1:0]  sel_data;
    logic [1:0]       sel_len;
    logic             resp_hs;
    logic             tmo_hit;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] p);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << p;
    endfunction

    // NOTE: every variable written in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
            cand = next_idx(cand);
        end
    end

    always_comb begin
        sel_type = bus.req_type[win_idx];
        sel_addr = bus.req_address[int'(win_idx) * XLEN +: XLEN];
        sel_data = bus.req_data[int'(win_idx) * XLEN +: XLEN];
        sel_len  = bus.req_length[int'(win_idx) * 2 +: 2];
    end

    assign resp_hs = (state_q == ST_WAIT) && bus.mem_resp_valid && bus.resp_ready[grant_q];

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        type_d   = type_q;
        addr_d   = addr_q;
        data_d   = data_q;
        len_d    = len_q;
        case (state_q)
            ST_IDLE: begin
                // The winner's req_ready is already high, so a valid winner is a handshake.
                if (win_found) begin
                    state_d = ST_ISSUE;
                    grant_d = win_idx;
                    type_d  = sel_type;
                    addr_d  = sel_addr;
                    data_d  = sel_data;
                    len_d   = sel_len;
                end
            end
            ST_ISSUE: begin
                if (bus.mem_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (resp_hs) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_idx(grant_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // An abandoned transaction still moves the pointer on, so the stuck requester is not retried first.
        if (tmo_hit) begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_idx(grant_q);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            // NOTE: the latched request fields are reset as well because mem_req_* must read 0 out of reset.
            type_q   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            type_q   <= type_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            len_q    <= len_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_err_q, tmo_err_d;

    // A completing response in the limit cycle wins over the watchdog.
    assign tmo_hit   = (state_q != ST_IDLE) && (tmo_cnt_q == TIMEOUT_CYCLES - 1) && !resp_hs;
    assign tmo_cnt_d = (state_q == ST_IDLE) ? '0 : tmo_cnt_q + 32'd1;
    assign tmo_err_d = tmo_err_q | tmo_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign bus.req_ready = (state_q == ST_IDLE && win_found) ? onehot(win_idx) : '0;

    assign bus.mem_req_type    = type_q;
    assign bus.mem_req_address = addr_q;
    assign bus.mem_req_data    = data_q;
    assign bus.mem_req_length  = len_q;
    assign bus.mem_req_valid   = (state_q == ST_ISSUE);

    // Response path is a pure pass-through steered by the latched grant.
    assign bus.resp_address   = bus.mem_resp_address;
    assign bus.resp_data      = bus.mem_resp_data;
    assign bus.resp_valid     = (state_q == ST_WAIT && bus.mem_resp_valid) ? onehot(grant_q) : '0;
    assign bus.mem_resp_ready = (state_q == ST_WAIT) && bus.resp_ready[grant_q];

    assign busy = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with three requesters and hand-computed expectations.
// Define MEM_ARB_TIMEOUT_EN to also exercise the watchdog with TIMEOUT_CYCLES = 16.
module tb_mem_port_arbiter;
    localparam int NUM_REQ = 3;
    localparam int XLEN    = 32;

    logic clk = 1'b0;
    logic reset_n;
    logic busy;
    logic timeout_err;
    logic ok;

    int n_checks = 0;
    int n_pass   = 0;

    mem_port_arbiter_if #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) bus ();

    mem_port_arbiter #(
        .NUM_REQ(NUM_REQ),
        .XLEN   (XLEN)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic t, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] l);
        bus.req_type[i]                 = t;
        bus.req_address[i*XLEN +: XLEN] = a;
        bus.req_data[i*XLEN +: XLEN]    = d;
        bus.req_length[i*2 +: 2]        = l;
    endtask

    logic [2:0]  rr_ready [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [31:0] rr_addr  [6] = '{32'hA000, 32'hA010, 32'hA020, 32'hA000, 32'hA010, 32'hA020};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n              = 1'b0;
        bus.req_type         = '0;
        bus.req_address      = '0;
        bus.req_data         = '0;
        bus.req_length       = '0;
        bus.req_valid        = 3'b110;
        bus.resp_ready       = '0;
        bus.mem_req_ready    = 1'b0;
        bus.mem_resp_address = '0;
        bus.mem_resp_data    = '0;
        bus.mem_resp_valid   = 1'b0;

        // Reset state; req_ready stays combinational in IDLE, rr_ptr=0 picks requester 1
        #2;
        check("rst_busy", busy, 0);
        check("rst_mem_req_valid", bus.mem_req_valid, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_mem_resp_ready", bus.mem_resp_ready, 0);
        check("rst_mem_req_fields", {bus.mem_req_type, bus.mem_req_length, bus.mem_req_address, bus.mem_req_data}, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_req_ready", bus.req_ready, 3'b010);
        bus.req_valid = '0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Single read from requester 1, memory answers 6 cycles after accepting
        set_req(1, 1'b0, 32'h1000, 32'h0, 2'd2);
        bus.req_valid = 3'b010;
        #1;
        check("rd_req_ready", bus.req_ready, 3'b010);
        tick();
        bus.req_valid = '0;
        check("rd_issue_valid", bus.mem_req_valid, 1);
        check("rd_issue_addr", bus.mem_req_address, 32'h1000);
        check("rd_issue_type", bus.mem_req_type, 0);
        check("rd_busy", busy, 1);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        ok = 1'b1;
        repeat (5) begin
            if (bus.resp_valid !== 3'b000 || bus.mem_req_valid !== 1'b0) ok = 1'b0;
            tick();
        end
        check("rd_quiet_wait", ok, 1);
        bus.resp_ready       = '1;
        bus.mem_resp_address = 32'h1000;
        bus.mem_resp_data    = 32'hDEADBEEF;
        bus.mem_resp_valid   = 1'b1;
        #1;
        check("rd_resp_valid", bus.resp_valid, 3'b010);
        check("rd_resp_data", bus.resp_data, 32'hDEADBEEF);
        check("rd_resp_addr", bus.resp_address, 32'h1000);
        check("rd_mem_resp_ready", bus.mem_resp_ready, 1);
        tick();
        bus.mem_resp_valid = 1'b0;
        check("rd_back_idle", busy, 0);

        // Async reset mid-WAIT with rr_ptr=2; requester 2 is in flight
        set_req(2, 1'b0, 32'h4000, 32'h0, 2'd2);
        bus.req_valid = 3'b100;
        #1;
        check("rst_wait_grant", bus.req_ready, 3'b100);
        tick();
        bus.req_valid     = '0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.resp_ready     = '0;
        bus.mem_resp_valid = 1'b1;
        #1;
        check("rst_wait_resp", bus.resp_valid, 3'b100);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_mem_req_valid", bus.mem_req_valid, 0);
        check("rst_mid_resp_valid", bus.resp_valid, 0);
        check("rst_mid_mem_resp_ready", bus.mem_resp_ready, 0);
        bus.mem_resp_valid = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;

        // Round-robin with every requester holding req_valid
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 32'hA000 + 32'(i) * 32'h10, 32'h0, 2'd2);
        bus.req_valid  = 3'b111;
        bus.resp_ready = '1;
        #1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("rr_ready_%0d", k), bus.req_ready, rr_ready[k]);
            tick();
            check($sformatf("rr_addr_%0d", k), bus.mem_req_address, rr_addr[k]);
            bus.mem_req_ready = 1'b1;
            tick();
            bus.mem_req_ready    = 1'b0;
            bus.mem_resp_address = rr_addr[k];
            bus.mem_resp_valid   = 1'b1;
            #1;
            check($sformatf("rr_resp_%0d", k), bus.resp_valid, rr_ready[k]);
            check($sformatf("rr_no_accept_%0d", k), bus.req_ready, 3'b000);
            tick();
            bus.mem_resp_valid = 1'b0;
            #1;
        end
        bus.req_valid = '0;

        // Write pass-through from requester 0 (rr_ptr=0)
        set_req(0, 1'b1, 32'h2004, 32'h11223344, 2'd2);
        bus.req_valid = 3'b001;
        #1;
        check("wr_req_ready", bus.req_ready, 3'b001);
        tick();
        bus.req_valid = '0;
        check("wr_mem_type", bus.mem_req_type, 1);
        check("wr_mem_len", bus.mem_req_length, 2);
        check("wr_mem_data", bus.mem_req_data, 32'h11223344);
        check("wr_mem_addr", bus.mem_req_address, 32'h2004);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready    = 1'b0;
        bus.mem_resp_address = 32'h2004;
        bus.mem_resp_data    = 32'h0;
        bus.mem_resp_valid   = 1'b1;
        #1;
        check("wr_resp_valid", bus.resp_valid, 3'b001);
        check("wr_resp_addr", bus.resp_address, 32'h2004);
        tick();
        bus.mem_resp_valid = 1'b0;

        // Backpressure on both memory handshakes, requester 2 (rr_ptr=1, only 2 valid)
        set_req(2, 1'b0, 32'h3000, 32'h0, 2'd1);
        bus.req_valid = 3'b100;
        #1;
        check("bp_req_ready", bus.req_ready, 3'b100);
        tick();
        bus.req_valid = 3'b011;
        ok = 1'b1;
        repeat (4) begin
            #1;
            if (bus.mem_req_valid !== 1'b1 || bus.mem_req_address !== 32'h3000 ||
                bus.mem_req_length !== 2'd1 || bus.req_ready !== 3'b000) ok = 1'b0;
            tick();
        end
        check("bp_req_stall", ok, 1);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready    = 1'b0;
        bus.resp_ready       = '0;
        bus.mem_resp_address = 32'h3000;
        bus.mem_resp_data    = 32'h55AA;
        bus.mem_resp_valid   = 1'b1;
        ok = 1'b1;
        repeat (3) begin
            #1;
            if (bus.mem_resp_ready !== 1'b0 || busy !== 1'b1 ||
                bus.resp_valid !== 3'b100 || bus.req_ready !== 3'b000) ok = 1'b0;
            tick();
        end
        check("bp_resp_stall", ok, 1);
        bus.resp_ready = 3'b100;
        #1;
        check("bp_resp_release", bus.mem_resp_ready, 1);
        tick();
        bus.mem_resp_valid = 1'b0;
        #1;
        check("bp_next_grant", bus.req_ready, 3'b001);
        bus.req_valid  = '0;
        bus.resp_ready = '1;

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory accepts but never responds; watchdog fires 16 cycles after ISSUE entry
        set_req(0, 1'b0, 32'h5000, 32'h0, 2'd2);
        bus.req_valid = 3'b001;
        tick();
        bus.req_valid     = '0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        repeat (14) tick();
        check("tmo_not_yet", timeout_err, 0);
        check("tmo_still_busy", busy, 1);
        tick();
        check("tmo_flag", timeout_err, 1);
        check("tmo_idle", busy, 0);
        bus.req_valid = 3'b011;
        #1;
        check("tmo_next_grant", bus.req_ready, 3'b010);
        bus.req_valid = '0;
        repeat (3) tick();
        check("tmo_sticky", timeout_err, 1);
`else
        check("no_timeout_flag", timeout_err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
